// File: rtl/gshare_bpred.sv
// gshare branch direction predictor.
// A pattern table of saturating counters is indexed by fetch PC XOR global
// history. Predictions are queued in program order in a small FIFO together
// with their table index and the history snapshot, so that an in-order
// resolution can train the right counter and repair history on a mispredict.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | sweeping the pattern table to weakly-taken, one entry a cycle
// RUN   | predicting, queueing in-flight branches, training on resolve
module gshare_bpred #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic                i_Stall,
  input  logic                i_pred_valid,
  input  logic [PC_WIDTH-1:0] i_pred_pc,
  output logic                o_pred_ready,
  output logic                o_taken,
  input  logic                i_res_valid,
  input  logic                i_res_taken,
  output logic                o_mispredict,
  output logic                o_res_error,
  output logic [15:0]         o_miss_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  mispredict_q;
  logic                  res_error_q;
  logic [15:0]           miss_count_q;

  logic [CTR_BITS-1:0]   table_q    [ENTRIES];
  logic [INDEX_BITS-1:0] fifo_idx_q [FIFO_DEPTH];
  logic                  fifo_pred_q[FIFO_DEPTH];
  logic [GHR_BITS-1:0]   fifo_ghr_q [FIFO_DEPTH];

  logic                  run;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pred_ready;
  logic                  taken;
  logic                  accept;
  logic                  pop;
  logic                  mispredict;
  logic                  push;
  logic                  res_err_evt;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_pred;
  logic [GHR_BITS-1:0]   head_ghr;
  logic [CTR_BITS-1:0]   head_ctr;
  logic [CTR_BITS-1:0]   head_ctr_upd;

  // Only PC bits [INDEX_BITS+1:2] index the table; the rest are don't-care.
  logic unused_pc_bits;
  assign unused_pc_bits = ^i_pred_pc;

  // Shift a new outcome into the youngest history position (works for GHR_BITS=1).
  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] h,
                                                    input logic              b);
    logic [GHR_BITS-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  // Prediction lookup, FIFO head decode and resolution qualification.
  always_comb begin
    run         = (state_q == S_RUN);
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CNT_FULL);
    pred_idx    = i_pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    taken       = run & table_q[pred_idx][CTR_BITS-1];
    pred_ready  = run & ~i_Stall & ~fifo_full;
    accept      = i_pred_valid & pred_ready;

    head_idx    = fifo_idx_q[rd_ptr_q];
    head_pred   = fifo_pred_q[rd_ptr_q];
    head_ghr    = fifo_ghr_q[rd_ptr_q];

    pop         = run & i_res_valid & ~fifo_empty;
    res_err_evt = run & i_res_valid & fifo_empty;
    mispredict  = pop & (i_res_taken != head_pred);
    // A mispredict flushes everything younger, including this cycle's fetch.
    push        = accept & ~mispredict;

    head_ctr     = table_q[head_idx];
    head_ctr_upd = head_ctr;
    if (i_res_taken) begin
      if (head_ctr != CTR_MAX) head_ctr_upd = head_ctr + 1'b1;
    end else begin
      if (head_ctr != '0) head_ctr_upd = head_ctr - 1'b1;
    end
  end

  assign o_pred_ready = pred_ready;
  assign o_taken      = taken;
  assign o_mispredict = mispredict_q;
  assign o_res_error  = res_error_q;
  assign o_miss_count = miss_count_q;

  // Next-state for the FSM, sweep pointer, history and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    ghr_d    = ghr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (mispredict) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          ghr_d    = ghr_shift(head_ghr, i_res_taken);
        end else begin
          if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            ghr_d    = ghr_shift(ghr_q, taken);
          end
          if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
          case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control registers and registered status outputs, synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      ghr_q        <= '1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      res_error_q  <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ghr_q        <= ghr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict;
      res_error_q  <= res_error_q | res_err_evt;
      if (mispredict && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  // Pattern table: swept to weakly-taken in INIT, trained by resolutions in RUN.
  always_ff @(posedge i_Clk) begin
    if (i_Reset_n) begin
      if (state_q == S_INIT) begin
        table_q[sweep_q] <= CTR_WEAK;
      end else if (pop) begin
        table_q[head_idx] <= head_ctr_upd;
      end
    end
  end

  // In-flight branch storage; validity is tracked by count_q, so no reset.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= pred_idx;
      fifo_pred_q[wr_ptr_q] <= taken;
      fifo_ghr_q[wr_ptr_q]  <= ghr_q;
    end
  end

endmodule

// File: tb/tb_gshare_bpred.sv
// Bench for gshare_bpred: directed vector table, reset/sweep sequences and a
// randomized run compared against a queue-based reference model.
module tb_gshare_bpred;

  logic        i_Clk = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_Stall = 1'b0;
  logic        i_pred_valid = 1'b0;
  logic [31:0] i_pred_pc = '0;
  logic        i_res_valid = 1'b0;
  logic        i_res_taken = 1'b0;
  logic        o_pred_ready;
  logic        o_taken;
  logic        o_mispredict;
  logic        o_res_error;
  logic [15:0] o_miss_count;

  int n_cmp = 0;
  int n_err = 0;

  gshare_bpred #(
    .PC_WIDTH(32), .INDEX_BITS(8), .GHR_BITS(8), .CTR_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Stall(i_Stall),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc),
    .o_pred_ready(o_pred_ready), .o_taken(o_taken),
    .i_res_valid(i_res_valid), .i_res_taken(i_res_taken),
    .o_mispredict(o_mispredict), .o_res_error(o_res_error),
    .o_miss_count(o_miss_count)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, sample combinational outputs, clock, land 1ns past the edge.
  task automatic step(input bit rst_n, input bit pv, input logic [31:0] pc,
                      input bit rv, input bit rt, input bit st,
                      output bit a_rdy, output bit a_tk);
    i_Reset_n    = rst_n;
    i_pred_valid = pv;
    i_pred_pc    = pc;
    i_res_valid  = rv;
    i_res_taken  = rt;
    i_Stall      = st;
    #1;
    a_rdy = o_pred_ready;
    a_tk  = o_taken;
    @(posedge i_Clk);
    #1;
  endtask

  // Idle cycles out of reset with requests/resolutions offered; counts accepts.
  task automatic sweep_idle(input int n, output int nr, output int nt);
    bit r, t;
    nr = 0;
    nt = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, $urandom, 1'(i % 3 == 0), 1'($urandom_range(0, 1)), 1'b0, r, t);
      if (r) nr++;
      if (t) nt++;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    bit pred;
    int ghr;
  } ent_t;

  ent_t m_q[$];
  int   m_tbl[256];
  int   m_ghr;
  int   m_init_left;
  bit   m_run;
  bit   m_mp;
  bit   m_err;
  int   m_miss;

  task automatic model_step(input bit rst_n, input bit pv, input logic [31:0] pc,
                            input bit rv, input bit rt, input bit st,
                            output bit e_rdy, output bit e_tk);
    int   idx;
    ent_t h;
    bit   acc;
    e_rdy = 1'b0;
    e_tk  = 1'b0;
    if (!rst_n) begin
      m_ghr = 255; m_q.delete(); m_mp = 0; m_err = 0; m_miss = 0;
      m_run = 0; m_init_left = 256;
    end else if (!m_run) begin
      m_mp = 0;
      m_init_left--;
      if (m_init_left == 0) begin
        m_run = 1;
        foreach (m_tbl[i]) m_tbl[i] = 2;
      end
    end else begin
      m_mp  = 0;
      idx   = ((pc / 4) % 256) ^ m_ghr;
      e_tk  = (m_tbl[idx] >= 2);
      e_rdy = !st && (m_q.size() < 4);
      acc   = pv && e_rdy;
      if (rv) begin
        if (m_q.size() == 0) begin
          m_err = 1;
        end else begin
          h = m_q.pop_front();
          if (rt) begin
            if (m_tbl[h.idx] < 3) m_tbl[h.idx]++;
          end else begin
            if (m_tbl[h.idx] > 0) m_tbl[h.idx]--;
          end
          if (rt != h.pred) begin
            m_q.delete();
            m_ghr = (h.ghr * 2 + int'(rt)) % 256;
            m_mp  = 1;
            if (m_miss < 65535) m_miss++;
            acc = 0;
          end
        end
      end
      if (acc) begin
        m_q.push_back('{idx, e_tk, m_ghr});
        m_ghr = (m_ghr * 2 + int'(e_tk)) % 256;
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          pv;
    logic [31:0] pc;
    bit          rv;
    bit          rt;
    bit          st;
    bit          rdy;
    bit          tk;
    bit          mp;
    int          miss;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit r, t, er, et, rst, pv, rv, rt, st;
    int nr, nt;
    logic [31:0] pc;

    //             pv  pc        rv rt st  rdy tk mp miss err
    vecs.push_back('{1, 32'h040,  0, 0, 0,  1,  1, 0, 0, 0}); // EF=2 -> push, GHR FF
    vecs.push_back('{0, 32'h040,  1, 0, 0,  1,  1, 1, 1, 0}); // miss, EF 2->1, GHR FE
    vecs.push_back('{1, 32'h044,  0, 0, 0,  1,  0, 0, 1, 0}); // idx EF=1 -> NT
    vecs.push_back('{0, 32'h044,  1, 0, 0,  1,  1, 0, 1, 0}); // correct, EF 1->0, GHR FC
    vecs.push_back('{1, 32'h04C,  0, 0, 0,  1,  0, 0, 1, 0}); // idx EF=0
    vecs.push_back('{0, 32'h04C,  1, 0, 0,  1,  1, 0, 1, 0}); // correct, EF holds 0
    vecs.push_back('{0, 32'h05C,  0, 0, 0,  1,  0, 0, 1, 0}); // idx EF still 0
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 1, 0}); // push B8
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 1, 0}); // push B1
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 1, 0}); // push A3
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 1, 0}); // push 87, full
    vecs.push_back('{1, 32'h100,  0, 0, 0,  0,  1, 0, 1, 0}); // full, refused
    vecs.push_back('{1, 32'h100,  1, 1, 0,  0,  1, 0, 1, 0}); // pop B8 while full
    vecs.push_back('{1, 32'h100,  1, 1, 0,  1,  1, 0, 1, 0}); // pop+push at 3
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 1, 0}); // push, full again
    vecs.push_back('{1, 32'h100,  0, 0, 0,  0,  1, 0, 1, 0}); // still 4 in flight
    vecs.push_back('{1, 32'h100,  1, 0, 0,  0,  1, 1, 2, 0}); // head A3 missed, GHR C6
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 2, 0}); // push 86 snap C6
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 2, 0}); // push CD
    vecs.push_back('{1, 32'h100,  0, 0, 0,  1,  1, 0, 2, 0}); // push 5B
    vecs.push_back('{1, 32'h100,  1, 0, 0,  1,  1, 1, 3, 0}); // miss, push dropped, GHR 8C
    vecs.push_back('{1, 32'h028,  0, 0, 0,  1,  0, 0, 3, 0}); // idx 86=1 proves GHR 8C
    vecs.push_back('{0, 32'h028,  1, 0, 0,  1,  1, 0, 3, 0}); // head is the new push
    vecs.push_back('{0, 32'h028,  1, 1, 0,  1,  1, 0, 3, 1}); // resolve on empty
    vecs.push_back('{0, 32'h278,  0, 0, 0,  1,  0, 0, 3, 1}); // idx 86=0, GHR 18 kept
    vecs.push_back('{1, 32'h278,  0, 0, 1,  0,  0, 0, 3, 1}); // stall blocks accept
    vecs.push_back('{0, 32'h278,  0, 0, 0,  1,  0, 0, 3, 1}); // GHR held through stall

    // Reset state.
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, r, t);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, r, t);
    check("reset_mispredict", o_mispredict, 0);
    check("reset_res_error", o_res_error, 0);
    check("reset_miss_count", o_miss_count, 0);

    // Sweep length: 256 cycles not ready, ready on the 257th.
    sweep_idle(256, nr, nt);
    check("init_ready_cycles", nr, 0);
    check("init_taken_cycles", nt, 0);
    check("init_res_ignored", o_res_error, 0);
    step(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, r, t);
    check("ready_on_cycle_257", r, 1);
    check("weak_taken_after_sweep", t, 1);

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].rt, vecs[i].st, r, t);
      check($sformatf("vec%0d_ready", i), r, vecs[i].rdy);
      check($sformatf("vec%0d_taken", i), t, vecs[i].tk);
      check($sformatf("vec%0d_mispredict", i), o_mispredict, vecs[i].mp);
      check($sformatf("vec%0d_miss_count", i), o_miss_count, vecs[i].miss);
      check($sformatf("vec%0d_res_error", i), o_res_error, vecs[i].err);
    end

    // Reset mid-RUN, then again mid-sweep at entry 100: full re-sweep from 0.
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, r, t);
    check("reset_clears_res_error", o_res_error, 0);
    check("reset_clears_miss_count", o_miss_count, 0);
    sweep_idle(100, nr, nt);
    check("partial_sweep_ready", nr, 0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, r, t);
    sweep_idle(256, nr, nt);
    check("resweep_ready_cycles", nr, 0);
    step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, r, t);
    check("resweep_ready_257", r, 1);
    check("resweep_entry_ef_weak", t, 1);
    check("resweep_res_error", o_res_error, 0);

    // Randomized run against the reference model, with occasional resets.
    model_step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, er, et);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, r, t);
    for (int c = 0; c < 4000; c++) begin
      rst = !((c == 2100) || ($urandom_range(0, 1999) == 0));
      pv  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 4);
      rt  = ($urandom_range(0, 9) < 7);
      st  = ($urandom_range(0, 9) < 2);
      pc  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      model_step(rst, pv, pc, rv, rt, st, er, et);
      step(rst, pv, pc, rv, rt, st, r, t);
      if (rst) begin
        check($sformatf("rnd%0d_ready", c), r, er);
        check($sformatf("rnd%0d_taken", c), t, et);
      end
      check($sformatf("rnd%0d_mispredict", c), o_mispredict, m_mp);
      check($sformatf("rnd%0d_res_error", c), o_res_error, m_err);
      check($sformatf("rnd%0d_miss_count", c), o_miss_count, m_miss);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
